// File: rtl/uart_rx.sv
// uart_rx: serial receiver with two-flop synchroniser, false-start rejection and framing-error detection
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   state_t state, state_n;
   logic rx_m, rx_s;
   logic [CW-1:0] cnt;
   logic [BW-1:0] idx;
   logic [DATA_BITS-1:0] shreg;
   logic sample, shift, load, ferr;
   // next state and sample strobes; a single mid-bit sample decides each bit
   always_comb begin
      state_n = state;
      sample = 1'b0;
      shift = 1'b0;
      load = 1'b0;
      ferr = 1'b0;
      case (state)
         IDLE: state_n = rx_s ? IDLE : START;
         START: begin
            sample = (cnt == HALF);
            if (sample) state_n = rx_s ? IDLE : DATA;
         end
         DATA: begin
            sample = (cnt == FULL);
            shift = sample;
            if (sample && idx == LAST) state_n = STOP;
         end
         STOP: begin
            sample = (cnt == FULL);
            load = sample && rx_s;
            ferr = sample && !rx_s;
            if (sample) state_n = rx_s ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
         default: state_n = IDLE;
      endcase
   end
   // two-flop synchroniser; the line idles high so both flops reset to 1
   always_ff @(posedge i_clk) begin
      if (i_rst) {rx_s, rx_m} <= 2'b11;
      else {rx_s, rx_m} <= {rx_m, i_rx};
   end
   // FSM state register
   always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
   // cycle counter restarts on every state entry and after each sample, idles at 0 when not timing a bit
   always_ff @(posedge i_clk) begin
      cnt <= (i_rst || sample || state_n != state || state == IDLE || state == WAIT_HIGH) ? '0 : cnt + 1'b1;
   end
   // bit index held at 0 outside DATA, advanced on each data sample except the last
   always_ff @(posedge i_clk) begin
      if (i_rst || state != DATA) idx <= '0;
      else if (shift && idx != LAST) idx <= idx + 1'b1;
   end
   // LSB-first shift register and registered output strobes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shreg <= '0;
         o_data <= '0;
         o_valid <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         if (shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         if (load) o_data <= shreg;
         o_valid <= load;
         o_frame_err <= ferr;
      end
   end
   assign o_busy = (state != IDLE);
endmodule
